// File: rtl/seq_det_pkg.sv
// Shared state encodings for the serial pattern detector and its word-level controller.
package seq_det_pkg;

    // Each detector state names the input suffix relevant to 010 / 1001.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // empty
        S1 = 3'd1,  // "0" / "00"
        S2 = 3'd2,  // "01"
        S3 = 3'd3,  // "10"
        S4 = 3'd4,  // "1" / "11"
        S5 = 3'd5   // "100"
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/seq_det_core.sv
// Overlapping Mealy detector for 010 and 1001; advances one bit per enabled cycle.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic hit
);

    det_state_t state;
    det_state_t state_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S0:      state_next = x ? S4 : S1;
            S1:      state_next = x ? S2 : S1;
            S2:      state_next = x ? S4 : S3;
            S3:      state_next = x ? S2 : S5;
            S4:      state_next = x ? S4 : S3;
            S5:      state_next = x ? S2 : S1;
            default: state_next = S0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else if (clr) begin
            state <= S0;
        end else if (en) begin
            state <= state_next;
        end
    end

    assign hit = ((state == S2) && !x) || ((state == S5) && x);

endmodule

// File: rtl/seq_det_frame_ctrl.sv
// Word-level scheduler: accepts a parallel word, shifts it MSB-first through the
// detector and returns the saturating per-word detection count.
module seq_det_frame_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last_hit,
    output logic              busy
);

    localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    ctrl_state_t       state;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              det_clr;
    logic              det_en;
    logic              det_x;
    logic              det_hit;

    // Flush clears history on the accept edge so the first bit sees an empty detector.
    assign det_clr  = (state == IDLE) && in_valid && in_ready && in_flush;
    assign det_en   = (state == SHIFT);
    assign det_x    = shreg[WORD_W-1];
    assign cnt_next = (det_hit && (match_cnt != {CNT_W{1'b1}})) ? match_cnt + CNT_W'(1) : match_cnt;

    seq_det_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (det_en),
        .x     (det_x),
        .hit   (det_hit)
    );

    // Results live in their own registers so they stay put while the next word's count restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            match_cnt    <= '0;
            out_count    <= '0;
            out_last_hit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg     <= in_data;
                        bit_cnt   <= '0;
                        match_cnt <= '0;
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg     <= {shreg[WORD_W-2:0], 1'b0};
                    match_cnt <= cnt_next;
                    bit_cnt   <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        out_count    <= cnt_next;
                        out_last_hit <= det_hit;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Scoreboard bench: two controllers (CNT_W=4 and CNT_W=2) share stimulus; a suffix-history
// model predicts each word's count and last-bit hit.
module tb_seq_det_frame_ctrl;

    localparam int WORD_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_flush = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid, out_last_hit, busy;
    logic [3:0]        out_count;
    logic              in_ready_s, out_valid_s, out_last_hit_s, busy_s;
    logic [1:0]        out_count_s;

    always #5 clk = ~clk;

    seq_det_frame_ctrl #(.WORD_W(WORD_W), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flush(in_flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_last_hit(out_last_hit),
        .busy(busy)
    );

    seq_det_frame_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_flush(in_flush), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_count(out_count_s), .out_last_hit(out_last_hit_s),
        .busy(busy_s)
    );

    typedef struct {
        logic [3:0] cnt4;
        logic [1:0] cnt2;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] hist = '0;
    int         hlen = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model: a hit is any bit that completes 010 or 1001 within the unflushed history.
    task automatic model_word(input logic [WORD_W-1:0] d, input logic f);
        exp_t e;
        int   hits = 0;
        logic h;
        if (f) hlen = 0;
        e.last = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            hist = {hist[2:0], d[i]};
            if (hlen < 4) hlen++;
            h = (hlen >= 3 && hist[2:0] == 3'b010) || (hlen >= 4 && hist == 4'b1001);
            if (h) hits++;
            if (i == 0) e.last = h;
        end
        e.cnt4 = (hits > 15) ? 4'd15 : 4'(hits);
        e.cnt2 = (hits > 3) ? 2'd3 : 2'(hits);
        sb.push_back(e);
    endtask

    task automatic send(input logic [WORD_W-1:0] d, input logic f);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_flush = f;
        @(posedge clk);
        model_word(d, f);
        @(negedge clk);
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic receive(input int hold);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WORD_W));
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("out_valid_s", 32'(out_valid_s), 32'd1);
        check("out_count", 32'(out_count), 32'(e.cnt4));
        check("out_count_sat", 32'(out_count_s), 32'(e.cnt2));
        check("out_last_hit", 32'(out_last_hit), 32'(e.last));
        check("out_last_hit_s", 32'(out_last_hit_s), 32'(e.last));
        check("busy_done", 32'(busy), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA5;
            in_flush = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_count", 32'(out_count), 32'(e.cnt4));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        check("count_held", 32'(out_count), 32'(e.cnt4));
        if (hold > 0) begin
            @(negedge clk);
            check("no_queued_word", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_last_hit", 32'(out_last_hit), 32'd0);
        reset = 1'b1;

        send(8'h52, 1'b1); receive(0);
        send(8'hFF, 1'b1); receive(0);
        send(8'h00, 1'b1); receive(0);
        send(8'h01, 1'b1); receive(0);
        send(8'h00, 1'b0); receive(0);
        send(8'h01, 1'b1); receive(0);
        send(8'h00, 1'b1); receive(0);
        send(8'h52, 1'b1); receive(5);

        // Reset lands after four bits (0,1,0,1) have been fed; the word is dropped.
        send(8'h52, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy_s", 32'(busy_s), 32'd0);
        check("midrst_in_ready_s", 32'(in_ready_s), 32'd1);
        if (sb.size() != 0) void'(sb.pop_back());
        hlen = 0;
        @(negedge clk);
        reset = 1'b1;
        send(8'h00, 1'b0); receive(0);

        for (int k = 0; k < 8; k++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0));
            receive(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
